// File: rtl/rom_dl_pkg.sv
// Shared types and constants for the ROM download packer.
package rom_dl_pkg;

    localparam int unsigned DL_AW             = 23;
    localparam logic [7:0]  ROM_INDEX_DEFAULT = 8'd0;

    localparam logic [1:0] DS_LO   = 2'b01;
    localparam logic [1:0] DS_HI   = 2'b10;
    localparam logic [1:0] DS_BOTH = 2'b11;

    typedef struct packed {
        logic [DL_AW-1:0] addr;
        logic [1:0]       ds;
        logic [15:0]      data;
    } dl_word_t;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } issue_state_e;

endpackage

// File: rtl/rom_dl_fifo.sv
// Small synchronous show-ahead FIFO; pushes into a full FIFO are ignored.
module rom_dl_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW:0]      wptr_q;
    logic [PW:0]      rptr_q;
    logic             do_push;
    logic             do_pop;

    // Extra pointer bit distinguishes full from empty.
    assign empty   = (wptr_q == rptr_q);
    assign full    = (wptr_q[PW] != rptr_q[PW]) && (wptr_q[PW-1:0] == rptr_q[PW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rptr_q[PW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + (PW+1)'(1);
            if (do_pop)  rptr_q <= rptr_q + (PW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr_q[PW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/rom_dl_packer.sv
// Packs ioctl ROM download bytes into 16-bit SDRAM words and issues them
// over the toggle req/ack port; raises rom_loaded once everything is written.
module rom_dl_packer
    import rom_dl_pkg::*;
#(
    parameter logic [7:0]  ROM_INDEX  = ROM_INDEX_DEFAULT,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned AW         = DL_AW
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    input  logic          ioctl_download,
    input  logic [7:0]    ioctl_index,
    input  logic          ioctl_wr,
    input  logic [24:0]   ioctl_addr,
    input  logic [7:0]    ioctl_dout,
    output logic          port_req,
    input  logic          port_ack,
    output logic [AW-1:0] port_a,
    output logic [1:0]    port_ds,
    output logic [15:0]   port_d,
    output logic          port_we,
    output logic          rom_init,
    output logic          rom_loaded,
    output logic          overflow
);

    localparam int unsigned WW = $bits(dl_word_t);

    logic             wr_q;
    logic             rom_init_q;
    logic             stb_q;
    logic             stb_odd_q;
    logic [DL_AW-1:0] stb_waddr_q;
    logic [7:0]       stb_data_q;
    logic             rom_init_rise;
    logic             rom_init_fall;
    logic             dl_done_q;

    logic             pair_open_q, pair_open_d;
    dl_word_t         pair_q, pair_d;
    logic             pend_q, pend_d;
    dl_word_t         pend_word_q, pend_word_d;
    logic             flush_q, flush_d;
    logic             push;
    dl_word_t         push_word;

    logic             fifo_full;
    logic             fifo_empty;
    logic             pop;
    logic [WW-1:0]    fifo_rd;
    dl_word_t         rd_word;
    issue_state_e     state_q, state_d;

    logic             unused_addr_hi;

    assign unused_addr_hi = ^ioctl_addr[24:AW+1];

    assign rom_init      = ioctl_download && (ioctl_index == ROM_INDEX);
    assign rom_init_rise = rom_init && !rom_init_q;
    assign rom_init_fall = !rom_init && rom_init_q;
    assign rd_word       = dl_word_t'(fifo_rd);
    assign port_we       = rom_init || !fifo_empty || pair_open_q || (state_q == S_WAIT);

    // Byte strobe edge detect and capture of the byte being accepted.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            wr_q        <= 1'b0;
            rom_init_q  <= 1'b0;
            stb_q       <= 1'b0;
            stb_odd_q   <= 1'b0;
            stb_waddr_q <= '0;
            stb_data_q  <= '0;
            dl_done_q   <= 1'b0;
        end else begin
            wr_q        <= ioctl_wr;
            rom_init_q  <= rom_init;
            stb_q       <= ioctl_wr && !wr_q && rom_init;
            stb_odd_q   <= ioctl_addr[0];
            stb_waddr_q <= DL_AW'(ioctl_addr[AW:1]);
            stb_data_q  <= ioctl_dout;
            if (rom_init_fall)      dl_done_q <= 1'b1;
            else if (rom_init_rise) dl_done_q <= 1'b0;
        end
    end

    // Pairing: at most one FIFO push per cycle; a deferred push covers the
    // case where an odd byte must follow out the pair it could not join.
    always_comb begin
        pair_open_d = pair_open_q;
        pair_d      = pair_q;
        pend_d      = 1'b0;
        pend_word_d = pend_word_q;
        flush_d     = flush_q;
        push        = 1'b0;
        push_word   = pair_q;

        if (pend_q) begin
            push      = 1'b1;
            push_word = pend_word_q;
        end else if (stb_q) begin
            if (!stb_odd_q) begin
                push        = pair_open_q;
                pair_open_d = 1'b1;
                pair_d      = '{addr: stb_waddr_q, ds: DS_LO, data: {8'h00, stb_data_q}};
            end else if (pair_open_q && (pair_q.addr == stb_waddr_q)) begin
                push        = 1'b1;
                push_word   = '{addr: stb_waddr_q, ds: DS_BOTH, data: {stb_data_q, pair_q.data[7:0]}};
                pair_open_d = 1'b0;
            end else if (pair_open_q) begin
                push        = 1'b1;
                pend_d      = 1'b1;
                pend_word_d = '{addr: stb_waddr_q, ds: DS_HI, data: {stb_data_q, 8'h00}};
                pair_open_d = 1'b0;
            end else begin
                push      = 1'b1;
                push_word = '{addr: stb_waddr_q, ds: DS_HI, data: {stb_data_q, 8'h00}};
            end
        end else if (flush_q) begin
            push        = pair_open_q;
            pair_open_d = 1'b0;
            flush_d     = 1'b0;
        end

        if (rom_init_fall) flush_d = 1'b1;
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            pair_open_q <= 1'b0;
            pair_q      <= '0;
            pend_q      <= 1'b0;
            pend_word_q <= '0;
            flush_q     <= 1'b0;
        end else begin
            pair_open_q <= pair_open_d;
            pair_q      <= pair_d;
            pend_q      <= pend_d;
            pend_word_q <= pend_word_d;
            flush_q     <= flush_d;
        end
    end

    rom_dl_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (WW)
    ) u_fifo (
        .clk     (clk_sys),
        .rst_n   (reset_n),
        .push    (push),
        .wr_data (push_word),
        .pop     (pop),
        .rd_data (fifo_rd),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Issue FSM next-state logic.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (port_ack == port_req) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // SDRAM port registers and sticky status flags.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            port_req   <= 1'b0;
            port_a     <= '0;
            port_ds    <= '0;
            port_d     <= '0;
            rom_loaded <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            if (pop) begin
                port_a   <= AW'(rd_word.addr);
                port_ds  <= rd_word.ds;
                port_d   <= rd_word.data;
                port_req <= !port_req;
            end
            if (push && fifo_full) overflow <= 1'b1;
            else if (rom_init_rise) overflow <= 1'b0;
            if (dl_done_q && !rom_init && !flush_q && !pend_q && !stb_q && !pair_open_q &&
                fifo_empty && (state_q == S_IDLE) && (port_ack == port_req))
                rom_loaded <= 1'b1;
        end
    end

endmodule

// File: doc/rom_dl_packer.md
Name: rom_dl_packer

Overview:
- Sits between the data_io download stream and the SDRAM write port.
- Collects ioctl byte writes for the ROM index and packs even/odd byte pairs into 16-bit words with byte enables.
- Buffers the packed words in a small FIFO and issues them over the SDRAM toggle req/ack handshake.
- Generates rom_loaded once the download has ended and every word has been acknowledged. The core reset is derived from rom_loaded.

Parameters:
- ROM_INDEX, 0, ioctl_index value accepted as a ROM download.
- FIFO_DEPTH, 4, packed-word FIFO entries; must be a power of 2, minimum 2.
- AW, 23, SDRAM word address width.

Ports:
- clk_sys  in  1  system clock; the only clock.
- reset_n  in  1  asynchronous, active-low reset.
- ioctl_download  in  1  download in progress.
- ioctl_index  in  8  download target index.
- ioctl_wr  in  1  byte strobe, level; may stay high for more than one cycle.
- ioctl_addr  in  25  byte address.
- ioctl_dout  in  8  byte data.
- port_req  out  1  toggles once per issued word.
- port_ack  in  1  SDRAM toggles it to equal port_req when the write is done.
- port_a  out  AW  word address, ioctl_addr[AW:1].
- port_ds  out  2  byte enables: bit1 = odd/high byte, bit0 = even/low byte.
- port_d  out  16  write data: {odd byte, even byte}.
- port_we  out  1  high while a ROM write is outstanding or queued.
- rom_init  out  1  ioctl_download && ioctl_index==ROM_INDEX.
- rom_loaded  out  1  sticky; set after a completed and drained ROM download.
- overflow  out  1  sticky error flag: a byte was dropped because the FIFO was full.

Behaviour:
- Reset values: port_req=0, port_a=0, port_ds=0, port_d=0, port_we=0, rom_loaded=0, overflow=0. FIFO empty, pair register empty, FSM in IDLE.
- Strobe detection: an accepted byte is the registered rising edge of ioctl_wr while rom_init=1. It is processed 1 cycle after the edge. Writes with a non-ROM index are ignored.
- Pair register holds word address, ds and data.
  - Even byte: opens a new pair (ds=01, low byte).
  - Odd byte with the same word address: completes the pair (ds=11) and pushes it to the FIFO.
  - Odd byte with a different word address, or no open pair: the open pair, if any, is pushed first, then the odd byte is pushed as ds=10. These two pushes take consecutive cycles; the next byte edge is at least 2 cycles later by data_io timing.
  - Even byte arriving while a pair is open: the open pair is pushed as ds=01, then the new pair is opened.
- Flush: on the falling edge of rom_init, an open pair is pushed as-is.
- FIFO: FIFO_DEPTH entries of {AW addr, 2 ds, 16 data}.
  - Push when full: the word is dropped and overflow is set.
  - Push and pop in the same cycle: both are allowed.
- Issue FSM:
  - IDLE: if the FIFO is non-empty, pop, drive port_a/ds/d, toggle port_req, go to WAIT.
  - WAIT: when port_ack==port_req, go to IDLE. The next issue happens no earlier than the following cycle.
  - port_a/ds/d stay stable for the whole of WAIT.
- port_we = rom_init | FIFO non-empty | pair open | state==WAIT.
- rom_loaded is set when all of the following hold: rom_init has fallen, flush is done, the FIFO is empty, and the FSM is in IDLE with port_ack==port_req. It never clears except on reset_n.
- A new download (rising edge of rom_init) clears overflow but not rom_loaded.
- Asynchronous reset mid-transfer: all state returns to reset values. The SDRAM side must be reset together, because the toggle parity restarts at 0.
- Latency: ioctl_wr edge of an odd byte → port_req toggle is 3 cycles when the FIFO is empty and the FSM is idle (edge register, pair/push, pop/issue).

Decomposition:
- Shared package rom_dl_pkg:
  - typedef dl_word_t {addr[AW-1:0], ds[1:0], data[15:0]}.
  - FSM state enum {IDLE, WAIT}.
  - Constant ROM_INDEX_DEFAULT.
- One sub-module: rom_dl_fifo, a synchronous FIFO parameterised on depth and width. Interface: push, pop, full, empty; asynchronous active-low reset.
- The packer and issue FSM live in the top module.

Test Plan:
- Index 0: bytes AA@0x000, BB@0x001, ack returned 2 cycles after each req → one write: port_a=0, ds=11, d=0xBBAA, port_req toggles once, rom_loaded=1 after ioctl_download falls.
- Odd-length stream: bytes 11@0x10, 22@0x11, 33@0x12, then download ends → two writes: {a=8, ds=11, d=0x2211} and {a=9, ds=01, d=0x??33 (low byte 33)}.
- Stall: 12 bytes with ack held for 40 cycles, FIFO_DEPTH=4 → first 4 words + 1 in flight accepted, the rest dropped, overflow=1. A new download clears overflow.
- ioctl_index=1 download of 8 bytes → no port_req toggle, rom_init=0, rom_loaded stays 0.
- ioctl_wr held high for 3 cycles on one byte → exactly one byte accepted.
- reset_n pulled low during WAIT → all outputs 0 immediately (asynchronous). After release, a fresh 2-byte download completes with port_req toggling from 0.
